// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one imem read at a time over a
// req/ready handshake and presents fetched words to decode through a stallable register.
module pc_fetch_unit #(
    parameter int unsigned          PC_WIDTH    = 8,
    parameter int unsigned          INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [PC_WIDTH-1:0]    pc,
    input  logic [PC_WIDTH-1:0]    next_pc,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_target,
    input  logic                   stall,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ready,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   instr_valid,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic [PC_WIDTH-1:0]    instr_pc
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_KILL  = 2'd2
    } state_t;

    state_t                  state, state_n;
    logic [PC_WIDTH-1:0]     pending, pending_n;
    logic [PC_WIDTH-1:0]     pc_n;
    logic                    valid_n;
    logic [INSTR_WIDTH-1:0]  out_n;
    logic [PC_WIDTH-1:0]     ipc_n;
    logic                    req_c;
    logic                    capture_c;
    logic                    slot_free_c;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            pending     <= '0;
            instr_valid <= 1'b0;
            instr_out   <= '0;
            instr_pc    <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            pending     <= pending_n;
            instr_valid <= valid_n;
            instr_out   <= out_n;
            instr_pc    <= ipc_n;
        end
    end

    // Next-state, request and output-register update
    always_comb begin
        state_n     = state;
        pc_n        = pc;
        pending_n   = pending;
        valid_n     = instr_valid;
        out_n       = instr_out;
        ipc_n       = instr_pc;
        req_c       = 1'b0;
        capture_c   = 1'b0;
        slot_free_c = !instr_valid || !stall;

        // Decode consumes the held instruction whenever it is not stalling
        if (instr_valid && !stall) begin
            valid_n = 1'b0;
        end

        case (state)
            S_FETCH: begin
                req_c = slot_free_c && !branch_taken;
                if (branch_taken) begin
                    pc_n    = branch_target;
                    valid_n = 1'b0;
                end else if (req_c && imem_ready) begin
                    capture_c = 1'b1;
                end else if (req_c) begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                req_c = 1'b1;
                if (branch_taken) begin
                    valid_n = 1'b0;
                    if (imem_ready) begin
                        pc_n    = branch_target;
                        state_n = S_FETCH;
                    end else begin
                        pending_n = branch_target;
                        state_n   = S_KILL;
                    end
                end else if (imem_ready) begin
                    capture_c = 1'b1;
                    state_n   = S_FETCH;
                end
            end
            S_KILL: begin
                // Read for the old pc is still in flight; its data is dropped
                req_c   = 1'b1;
                valid_n = 1'b0;
                if (branch_taken) begin
                    pending_n = branch_target;
                end
                if (imem_ready) begin
                    pc_n    = branch_taken ? branch_target : pending;
                    state_n = S_FETCH;
                end
            end
            default: begin
                state_n = S_FETCH;
            end
        endcase

        if (capture_c) begin
            valid_n = 1'b1;
            out_n   = imem_rdata;
            ipc_n   = pc;
            pc_n    = next_pc;
        end
    end

    assign imem_req  = req_c && !rst;
    assign imem_addr = pc;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a transaction-level fetch model is compared
// against the DUT every cycle, plus hand-computed literal expectations.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst;
    logic [7:0]  pc;
    logic [7:0]  next_pc;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic        stall;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic [15:0] instr_out;
    logic [7:0]  instr_pc;

    int errors = 0;
    int checks = 0;

    pc_fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .pc            (pc),
        .next_pc       (next_pc),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .stall         (stall),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr_out     (instr_out),
        .instr_pc      (instr_pc)
    );

    // pc_adder and a memory whose word at address a is 0x1000+a
    assign next_pc    = 8'(pc + 8'd1);
    assign imem_rdata = 16'h1000 + 16'(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: one read in flight at most; a doomed read is one a branch has cancelled
    logic [7:0]  m_pc;
    logic        m_busy;
    logic        m_doomed;
    logic [7:0]  m_pend;
    logic        m_valid;
    logic [15:0] m_out;
    logic [7:0]  m_ipc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 8'h00; m_busy = 1'b0; m_doomed = 1'b0; m_pend = 8'h00;
        m_valid = 1'b0; m_out = 16'h0000; m_ipc = 8'h00;
    endtask

    task automatic deliver();
        m_valid = 1'b1;
        m_out   = 16'h1000 + 16'(m_pc);
        m_ipc   = m_pc;
        m_pc    = 8'(m_pc + 8'd1);
    endtask

    // Drive one cycle of inputs, compare everything, then advance the model past the edge
    task automatic drive(input logic r, input logic rdy, input logic stl,
                         input logic br, input logic [7:0] tgt);
        logic exp_req;
        @(negedge clk);
        rst = r; imem_ready = rdy; stall = stl; branch_taken = br; branch_target = tgt;
        #1;
        if (r)           exp_req = 1'b0;
        else if (m_busy) exp_req = 1'b1;
        else             exp_req = (!m_valid || !stl) && !br;
        chk("pc",          32'(pc),          32'(m_pc));
        chk("imem_addr",   32'(imem_addr),   32'(m_pc));
        chk("imem_req",    32'(imem_req),    32'(exp_req));
        chk("instr_valid", 32'(instr_valid), 32'(m_valid));
        chk("instr_out",   32'(instr_out),   32'(m_out));
        chk("instr_pc",    32'(instr_pc),    32'(m_ipc));

        if (r) begin
            model_reset();
        end else if (!m_busy) begin
            if (br) begin
                m_pc = tgt; m_valid = 1'b0;
            end else if (exp_req && rdy) begin
                deliver();
            end else begin
                if (m_valid && !stl) m_valid = 1'b0;
                if (exp_req) m_busy = 1'b1;
            end
        end else begin
            if (m_valid && !stl) m_valid = 1'b0;
            if (m_doomed) begin
                if (br) m_pend = tgt;
                if (rdy) begin
                    m_pc = m_pend; m_busy = 1'b0; m_doomed = 1'b0;
                end
            end else if (br) begin
                m_valid = 1'b0;
                if (rdy) begin
                    m_pc = tgt; m_busy = 1'b0;
                end else begin
                    m_pend = tgt; m_doomed = 1'b1;
                end
            end else if (rdy) begin
                deliver(); m_busy = 1'b0;
            end
        end
    endtask

    initial begin
        rst = 1'b1; imem_ready = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
        model_reset();
        @(posedge clk);

        // Reset held with ready high
        drive(1, 1, 0, 0, 8'h00);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_pc", 32'(pc), 32'h00);
        drive(1, 1, 0, 0, 8'h00);
        chk("rst_valid", 32'(instr_valid), 32'd0);

        // Zero-wait sequential fetch
        drive(0, 1, 0, 0, 8'h00);
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", 32'(imem_addr), 32'h00);
        drive(0, 1, 0, 0, 8'h00);
        chk("seq0_out", 32'(instr_out), 32'h1000);
        chk("seq0_pc", 32'(instr_pc), 32'h00);
        drive(0, 1, 0, 0, 8'h00);
        chk("seq1_out", 32'(instr_out), 32'h1001);
        drive(0, 1, 0, 0, 8'h00);
        chk("seq2_out", 32'(instr_out), 32'h1002);
        chk("seq2_pc", 32'(instr_pc), 32'h02);

        // Three wait states, then a four-cycle stall
        drive(1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 8'h00);
            chk("wait_addr", 32'(imem_addr), 32'h00);
        end
        drive(0, 1, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 0, 8'h00);
            chk("stall_req", 32'(imem_req), 32'd0);
            chk("stall_out", 32'(instr_out), 32'h1000);
        end
        drive(0, 0, 0, 0, 8'h00);
        chk("resume_addr", 32'(imem_addr), 32'h01);
        chk("resume_req", 32'(imem_req), 32'd1);
        drive(0, 1, 0, 0, 8'h00);

        // Redirect while the read at 0x05 is outstanding
        drive(0, 0, 0, 1, 8'h05);
        drive(0, 0, 0, 0, 8'h00);
        chk("pend_addr", 32'(imem_addr), 32'h05);
        drive(0, 0, 0, 1, 8'h40);
        drive(0, 0, 0, 0, 8'h00);
        chk("kill_addr", 32'(imem_addr), 32'h05);
        drive(0, 1, 0, 0, 8'h00);
        chk("kill_valid", 32'(instr_valid), 32'd0);
        drive(0, 1, 0, 0, 8'h00);
        chk("redir_addr", 32'(imem_addr), 32'h40);
        drive(0, 0, 1, 0, 8'h00);
        chk("redir_ipc", 32'(instr_pc), 32'h40);
        chk("redir_out", 32'(instr_out), 32'h1040);

        // Redirect under stall flushes the held instruction
        drive(0, 1, 1, 1, 8'h80);
        drive(0, 0, 1, 0, 8'h00);
        chk("flush_valid", 32'(instr_valid), 32'd0);
        chk("flush_pc", 32'(pc), 32'h80);
        drive(0, 1, 0, 0, 8'h00);

        // Branch coinciding with ready in WAIT
        drive(0, 0, 0, 0, 8'h00);
        drive(0, 1, 0, 1, 8'h20);
        drive(0, 0, 0, 0, 8'h00);
        chk("wbr_pc", 32'(pc), 32'h20);
        chk("wbr_valid", 32'(instr_valid), 32'd0);

        // Second branch in KILL replaces the pending target
        drive(0, 0, 0, 1, 8'h30);
        drive(0, 0, 0, 1, 8'h31);
        drive(0, 1, 0, 0, 8'h00);
        drive(0, 0, 0, 0, 8'h00);
        chk("kill2_pc", 32'(pc), 32'h31);
        drive(0, 1, 0, 0, 8'h00);

        // PC wrap at 0xFF
        drive(0, 0, 0, 1, 8'hFF);
        drive(0, 1, 0, 0, 8'h00);
        drive(0, 1, 1, 0, 8'h00);
        chk("wrap_pc", 32'(pc), 32'h00);
        chk("wrap_ipc", 32'(instr_pc), 32'hFF);
        chk("wrap_out", 32'(instr_out), 32'h10FF);
        chk("idle_ready_req", 32'(imem_req), 32'd0);

        // Reset in the middle of a wait
        drive(0, 1, 0, 0, 8'h00);
        drive(0, 0, 0, 0, 8'h00);
        drive(1, 1, 0, 0, 8'h00);
        chk("rst_wait_req", 32'(imem_req), 32'd0);
        drive(0, 0, 0, 0, 8'h00);
        chk("post_rst_pc", 32'(pc), 32'h00);
        drive(0, 1, 0, 0, 8'h00);
        drive(0, 0, 0, 0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
